// File: rtl/stack_ctrl_pkg.sv
// Shared op codes and FSM state encoding for the stack sequencing controller.
package stack_ctrl_pkg;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_PEEK    = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/stack_depth_tracker.sv
// Saturating occupancy counter with full/empty decode.
// Optional STACK_CTRL_WATERMARK_EN adds a registered almost_full flag.
module stack_depth_tracker #(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH) + 1
`ifdef STACK_CTRL_WATERMARK_EN
  , parameter int AF_MARGIN = 2
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
`ifdef STACK_CTRL_WATERMARK_EN
  , output logic             almost_full
`endif
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  logic [DEPTH_W-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (clk_en) begin
      if (inc && !dec && depth_q != DEPTH_MAX) begin
        depth_d = depth_q + DEPTH_W'(1);
      end else if (dec && !inc && depth_q != '0) begin
        depth_d = depth_q - DEPTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  assign depth = depth_q;
  assign full  = (depth_q == DEPTH_MAX);
  assign empty = (depth_q == '0);

`ifdef STACK_CTRL_WATERMARK_EN
  localparam logic [DEPTH_W-1:0] AF_LEVEL = DEPTH_W'(STACK_DEPTH - AF_MARGIN);

  logic almost_full_q, almost_full_d;

  // Decoded from the next depth so the flag lines up with o_depth.
  assign almost_full_d = (depth_d >= AF_LEVEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: rtl/stack_ctrl.sv
// Sequencing controller in front of the call/data stack: PUSH/POP/PEEK/REPLACE.
// Optional STACK_CTRL_WATERMARK_EN adds parameter AF_MARGIN and port o_almost_full.
//   state | meaning
//   IDLE  | ready for a request; op and data latched on accept
//   EXEC  | decide, strobe the stack, capture top-of-stack
//   EXEC2 | second half of REPLACE: push the latched data
//   RESP  | one enabled-cycle response pulse
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int STACK_WIDTH = 16,
  parameter int STACK_DEPTH = 16
`ifdef STACK_CTRL_WATERMARK_EN
  , parameter int AF_MARGIN = 2
`endif
  , localparam int DEPTH_W  = $clog2(STACK_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_clk_en,
  input  logic                   i_req_valid,
  input  logic [1:0]             i_req_op,
  input  logic [STACK_WIDTH-1:0] i_req_data,
  output logic                   o_req_ready,
  output logic                   o_rsp_valid,
  output logic [STACK_WIDTH-1:0] o_rsp_data,
  output logic                   o_rsp_err,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [DEPTH_W-1:0]     o_depth,
  output logic                   o_err_overflow,
  output logic                   o_err_underflow,
  input  logic                   i_err_clr,
  output logic                   o_stk_push,
  output logic                   o_stk_pop,
  output logic [STACK_WIDTH-1:0] o_stk_data,
  input  logic [STACK_WIDTH-1:0] i_stk_data
`ifdef STACK_CTRL_WATERMARK_EN
  , output logic                 o_almost_full
`endif
);

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [STACK_WIDTH-1:0] data_q, data_d;
  logic [STACK_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   ovf_set, udf_set;
  logic                   stk_push, stk_pop;
  logic                   full, empty;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          op_d    = i_req_op;
          data_d  = i_req_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q == OP_PUSH) begin
          state_d = IDLE;
          if (full) ovf_set  = 1'b1;
          else      stk_push = 1'b1;
        end else if (empty) begin
          udf_set    = 1'b1;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          rsp_data_d = i_stk_data;
          rsp_err_d  = 1'b0;
          stk_pop    = (op_q != OP_PEEK);
          state_d    = (op_q == OP_REPLACE) ? EXEC2 : RESP;
        end
      end
      EXEC2: begin
        stk_push = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new error on the same edge as a clear leaves the flag set.
    ovf_d = i_err_clr ? 1'b0 : ovf_q;
    udf_d = i_err_clr ? 1'b0 : udf_q;
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else if (i_clk_en) begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  stack_depth_tracker #(
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
`ifdef STACK_CTRL_WATERMARK_EN
    , .AF_MARGIN (AF_MARGIN)
`endif
  ) u_depth (
    .clk         (clk),
    .rst_n       (i_rst_n),
    .clk_en      (i_clk_en),
    .inc         (stk_push),
    .dec         (stk_pop),
    .depth       (o_depth),
    .full        (full),
    .empty       (empty)
`ifdef STACK_CTRL_WATERMARK_EN
    , .almost_full (o_almost_full)
`endif
  );

  assign o_req_ready     = (state_q == IDLE);
  assign o_rsp_valid     = (state_q == RESP);
  assign o_rsp_data      = rsp_data_q;
  assign o_rsp_err       = rsp_err_q;
  assign o_full          = full;
  assign o_empty         = empty;
  assign o_err_overflow  = ovf_q;
  assign o_err_underflow = udf_q;
  assign o_stk_push      = stk_push;
  assign o_stk_pop       = stk_pop;
  assign o_stk_data      = data_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl with a behavioural circular stack and a queue-based reference.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int DW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic          req_valid;
  logic [1:0]    req_op;
  logic [W-1:0]  req_data;
  logic          req_ready;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic          full;
  logic          empty;
  logic [DW-1:0] depth;
  logic          err_ovf;
  logic          err_udf;
  logic          err_clr;
  logic          stk_push;
  logic          stk_pop;
  logic [W-1:0]  stk_wdata;
  logic [W-1:0]  stk_rdata;
`ifdef STACK_CTRL_WATERMARK_EN
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  stack_ctrl #(.STACK_WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk             (clk),
    .i_rst_n         (rst_n),
    .i_clk_en        (clk_en),
    .i_req_valid     (req_valid),
    .i_req_op        (req_op),
    .i_req_data      (req_data),
    .o_req_ready     (req_ready),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_data      (rsp_data),
    .o_rsp_err       (rsp_err),
    .o_full          (full),
    .o_empty         (empty),
    .o_depth         (depth),
    .o_err_overflow  (err_ovf),
    .o_err_underflow (err_udf),
    .i_err_clr       (err_clr),
    .o_stk_push      (stk_push),
    .o_stk_pop       (stk_pop),
    .o_stk_data      (stk_wdata),
    .i_stk_data      (stk_rdata)
`ifdef STACK_CTRL_WATERMARK_EN
    , .o_almost_full (almost_full)
`endif
  );

  // Circular stack RAM without reset, gated by the same clock enable.
  logic [W-1:0] mem [D];
  logic [1:0]   sp = 2'd0;
  assign stk_rdata = mem[sp - 2'd1];
  always @(posedge clk) begin
    if (clk_en) begin
      if (stk_push) begin
        mem[sp] <= stk_wdata;
        sp      <= sp + 2'd1;
      end else if (stk_pop) begin
        sp <= sp - 2'd1;
      end
    end
  end

  typedef struct {
    logic         err;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t         sb[$];
  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf;
  int           tests = 0, fails = 0;
  int           push_cnt = 0, pop_cnt = 0;
  int           en_mode = 0;
  rsp_t         mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0: always enabled, 1: alternate, 2: random
  initial forever begin
    @(posedge clk);
    #2;
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = ~clk_en;
      default: clk_en = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && clk_en) begin
      if (stk_push) push_cnt++;
      if (stk_pop)  pop_cnt++;
      if (stk_push || stk_pop) chk("strobe_overlap", 32'(stk_push && stk_pop), 0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got data %0h err %0b, expected no response", rsp_data, rsp_err);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] d);
    bit got = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready && clk_en) got = 1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_data  = W'($urandom);
    if (!got) chk("accept_timeout", 1, 0);
  endtask

  task automatic check_status();
    chk("depth", 32'(depth), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("err_overflow", 32'(err_ovf), 32'(m_ovf));
    chk("err_underflow", 32'(err_udf), 32'(m_udf));
`ifdef STACK_CTRL_WATERMARK_EN
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= D - 2));
`endif
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] d);
    rsp_t e;
    int   n = 0, exp_lat = 2, exp_push = 0, exp_pop = 0, p0, q0;
    bit   got = 0;
    e.err  = 1'b1;
    e.data = '0;
    if (op == OP_PUSH) begin
      if (mq.size() < D) begin
        mq.push_back(d);
        exp_push = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (mq.size() == 0) begin
      m_udf = 1;
      sb.push_back(e);
    end else begin
      e.err  = 1'b0;
      e.data = mq[mq.size()-1];
      sb.push_back(e);
      if (op == OP_POP) begin
        void'(mq.pop_back());
        exp_pop = 1;
      end else if (op == OP_REPLACE) begin
        mq[mq.size()-1] = d;
        exp_pop  = 1;
        exp_push = 1;
        exp_lat  = 3;
      end
    end
    p0 = push_cnt;
    q0 = pop_cnt;
    issue(op, d);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (clk_en) begin
        n++;
        if (op == OP_PUSH) begin
          got = 1;
          chk("push_strobe", 32'(stk_push), 32'(exp_push));
        end else if (rsp_valid) begin
          got = 1;
          chk("latency", 32'(n), 32'(exp_lat));
        end
      end
    end
    if (!got) chk("op_timeout", 1, 0);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) chk("idle_timeout", 1, 0);
    #1;
    chk("push_count", 32'(push_cnt - p0), 32'(exp_push));
    chk("pop_count", 32'(pop_cnt - q0), 32'(exp_pop));
    check_status();
  endtask

  task automatic clear_errors();
    bit got = 0;
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (clk_en) got = 1;
    end
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_ovf = 0;
    m_udf = 0;
    @(negedge clk);
    #1;
    check_status();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_PUSH;
    req_data  = '0;
    err_clr   = 1'b0;
    #22;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_stk_push", 32'(stk_push), 0);
    chk("rst_stk_pop", 32'(stk_pop), 0);
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 1);

    do_op(OP_PUSH, 16'h1111);
    do_op(OP_PUSH, 16'h2222);
    do_op(OP_POP, '0);
    do_op(OP_POP, '0);

    for (int i = 0; i < D; i++) do_op(OP_PUSH, W'(16'hC000 + i));
    do_op(OP_PUSH, 16'hDEAD);
    for (int i = 0; i < D; i++) do_op(OP_POP, '0);

    do_op(OP_POP, '0);
    clear_errors();

    do_op(OP_PUSH, 16'hAAAA);
    do_op(OP_REPLACE, 16'hBBBB);
    do_op(OP_PEEK, '0);
    do_op(OP_POP, '0);

    en_mode = 1;
    do_op(OP_PUSH, 16'h1234);
    do_op(OP_REPLACE, 16'h4321);
    do_op(OP_PEEK, '0);
    do_op(OP_POP, '0);
    do_op(OP_REPLACE, 16'h7777);
    clear_errors();
    en_mode = 0;

    // Reset while the REPLACE push strobe is up: no response, depth back to 0.
    do_op(OP_PUSH, 16'h0F0F);
    issue(OP_REPLACE, 16'h9999);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (stk_push) got = 1;
    end
    chk("exec2_reached", 32'(got), 1);
    #1;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    chk("midrst_stk_push", 32'(stk_push), 0);
    chk("midrst_stk_pop", 32'(stk_pop), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    check_status();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_op(OP_PUSH, 16'h5555);
    do_op(OP_POP, '0);

    // Clear held across an overflow: the new error wins.
    for (int i = 0; i < D; i++) do_op(OP_PUSH, W'($urandom));
    do_op(OP_POP, '0);
    do_op(OP_PUSH, 16'h0101);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    m_ovf = 0;
    m_udf = 0;
    do_op(OP_PUSH, 16'hBEEF);
    err_clr = 1'b0;
    clear_errors();

    for (int k = 0; k < 80; k++) begin
      en_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) clear_errors();
      else do_op(2'($urandom_range(0, 3)), W'($urandom));
    end
    en_mode = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Sequencing controller in front of the hardware call/data stack (circular RAM, push/pop strobes, combinational top-of-stack output, no reset, no simultaneous push+pop). It accepts one operation at a time from the control unit over a valid/ready handshake: PUSH, POP, PEEK, or REPLACE. REPLACE is a pop followed by a push, issued as two stack cycles. The block tracks occupancy, reports full/empty, and blocks overflow and underflow so the stack pointer never wraps into live data.

Parameters:
STACK_WIDTH, 16, data width; must match the stack instance.
STACK_DEPTH, 16, number of stack entries; must match the stack instance; power of two.
DEPTH_W, $clog2(STACK_DEPTH)+1, width of the occupancy count (localparam).

Ports:
clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_clk_en  in  1  global clock enable; state advances only on enabled edges
i_req_valid  in  1  request present
i_req_op  in  2  00 PUSH, 01 POP, 10 PEEK, 11 REPLACE
i_req_data  in  STACK_WIDTH  push/replace data
o_req_ready  out  1  request accepted on an enabled edge with valid&ready
o_rsp_valid  out  1  one enabled-cycle pulse carrying a POP/PEEK/REPLACE result
o_rsp_data  out  STACK_WIDTH  old top-of-stack value
o_rsp_err  out  1  result invalid (underflow); o_rsp_data is 0
o_full  out  1  depth == STACK_DEPTH
o_empty  out  1  depth == 0
o_depth  out  DEPTH_W  current occupancy
o_err_overflow  out  1  sticky; set by PUSH when full
o_err_underflow  out  1  sticky; set by POP/PEEK/REPLACE when empty
i_err_clr  in  1  clears both sticky flags
o_stk_push  out  1  to stack i_push
o_stk_pop  out  1  to stack i_pop
o_stk_data  out  STACK_WIDTH  to stack i_load_data
i_stk_data  in  STACK_WIDTH  from stack o_data (top of stack)

Behaviour:
- Reset (async, i_rst_n low) sets:
  - state IDLE, depth 0, both sticky flags 0.
  - o_rsp_valid, o_rsp_err, o_stk_push and o_stk_pop all 0; o_rsp_data 0.
  - o_req_ready is 1 once reset deasserts.
- The stack is circular, so its absolute pointer does not matter; controller depth 0 is authoritative after any reset.
- Stack strobes decode from registered state only. Reset mid-operation drops them immediately, abandons the in-flight op, and produces no response.
- States:
  - IDLE: o_req_ready=1. On accept, latch op and data; go to EXEC.
  - EXEC: decide and act:
    - PUSH, not full: o_stk_push=1, o_stk_data=latched data, depth+1, back to IDLE.
    - PUSH, full: no strobe, set overflow, back to IDLE.
    - POP, not empty: o_stk_pop=1, capture i_stk_data into the response, depth-1, go to RESP.
    - PEEK, not empty: capture i_stk_data with no strobe, go to RESP.
    - REPLACE, not empty: o_stk_pop=1, capture i_stk_data, go to EXEC2.
    - POP/PEEK/REPLACE when empty: no strobe, set underflow, response err=1 with data 0, go to RESP.
  - EXEC2: o_stk_push=1 with latched data (depth unchanged net); go to RESP.
  - RESP: o_rsp_valid=1 for exactly one enabled cycle; go to IDLE.
- Latency, measured from the accept edge:
  - PUSH: strobe in the next cycle.
  - POP/PEEK: response 2 enabled cycles after accept.
  - REPLACE: response 3 enabled cycles after accept.
- o_stk_push and o_stk_pop are never high together.
- When i_clk_en=0, the state holds and strobes stay asserted; the stack ignores them because it also gates with clk_en.
- Response data is registered and held until the next response.
- i_err_clr and a new error on the same edge: the flag ends up set (set wins).
- The depth counter never exceeds STACK_DEPTH or drops below 0.

Optional Feature:
STACK_CTRL_WATERMARK_EN:
- Enabled: adds parameter AF_MARGIN (default 2) and output o_almost_full, registered, high when depth >= STACK_DEPTH-AF_MARGIN; reset value 0.
- Disabled: neither the port nor the logic exists.

Decomposition:
- Package stack_ctrl_pkg holds:
  - op code constants OP_PUSH, OP_POP, OP_PEEK, OP_REPLACE;
  - state encoding IDLE, EXEC, EXEC2, RESP.
- Sub-module stack_depth_tracker: saturating up/down occupancy counter with full/empty/almost_full decode and async reset.
- The FSM stays in stack_ctrl.

Test Plan (STACK_DEPTH=4, STACK_WIDTH=16):
1. PUSH 0x1111, 0x2222, then POP, POP -> responses 0x2222 then 0x1111, err=0; depth 0, o_empty=1.
2. PUSH 4 values -> o_full=1, depth 4. Fifth PUSH 0xDEAD -> no o_stk_push, o_err_overflow=1. POP -> 4th value.
3. POP when empty -> o_rsp_valid with err=1, data 0, o_err_underflow=1, no o_stk_pop. Then i_err_clr -> flag 0.
4. PUSH 0xAAAA, REPLACE 0xBBBB -> response 0xAAAA, pop and push strobes in consecutive cycles never overlapping, depth stays 1. PEEK -> 0xBBBB.
5. i_clk_en toggled 1/0 every cycle during a REPLACE -> identical results, with latencies counted in enabled cycles only.
6. Assert i_rst_n during EXEC2 of a REPLACE -> strobes drop asynchronously, depth 0, no response. PUSH 0x5555 then POP -> 0x5555.
